instr_mem_loadable: RTL and testbench

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

---
 rtl/instr_mem_loadable.sv | 168 ++++++++++++++++
 tb/tb_instr_mem_loadable.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// ============================================================================
// instr_mem_loadable
// ----------------------------------------------------------------------------
// Instruction memory that is filled by a streaming program loader and then
// serves single-cycle registered fetches.
//
// A load begins with load_start. From then on every load_valid beat writes
// load_data to the next sequential address, starting at 0. The load ends after
// the beat that carries load_last, or after the beat that fills the last word,
// whichever comes first. Fetches are accepted only when the memory is READY.
// Loading and fetching are mutually exclusive, so the array never has a read
// and a write in the same cycle.
//
// Parameters
//   DEPTH        number of instruction words (2..4096, any value)
//   INSTR_WIDTH  bits per instruction word
//   AW           fetch/write address width
//   NOP_WORD     word returned for out-of-range fetches and used as the reset
//                value of fetch_instr
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous active-high reset (memory array is not cleared)
//   load_start   begin a new program load at address 0 (any state)
//   load_valid   load_data is valid this cycle
//   load_data    next sequential program word
//   load_last    current load_valid word is the final one
//   ready        memory is loaded and fetches are accepted
//   load_count   words written in the current or most recent load
//   fetch_req    fetch request
//   fetch_addr   fetch address
//   fetch_stall  hold the fetch output registers and drop any request
//   fetch_valid  fetch_instr holds a returned word
//   fetch_instr  registered instruction
//   addr_err     returned fetch had fetch_addr >= DEPTH
// ============================================================================
module instr_mem_loadable #(
    parameter int                       DEPTH       = 256,
    parameter int                       INSTR_WIDTH = 9,
    parameter int                       AW          = $clog2(DEPTH),
    parameter logic [INSTR_WIDTH-1:0]   NOP_WORD    = '0
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [INSTR_WIDTH-1:0]  load_data,
    input  logic                    load_last,
    output logic                    ready,
    output logic [AW:0]             load_count,

    input  logic                    fetch_req,
    input  logic [AW-1:0]           fetch_addr,
    input  logic                    fetch_stall,
    output logic                    fetch_valid,
    output logic [INSTR_WIDTH-1:0]  fetch_instr,
    output logic                    addr_err
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // Address of the final word; a write here ends the load even without
    // load_last so the pointer never runs past the array.
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    // DEPTH widened by one bit so the range check also works when DEPTH is
    // exactly 2**AW.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    logic [1:0]             state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   err_q, err_d;

    logic                   mem_we;
    logic                   fetch_fire;
    logic                   addr_in_range;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    // Load sequencing. load_start wins over a same-cycle load_valid so a
    // restart always begins cleanly at address 0. Beats outside LOAD are
    // ignored. An unused state encoding falls back to EMPTY.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_we  = 1'b0;
        if (load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            count_d = '0;
        end else if (state_q == ST_LOAD) begin
            if (load_valid) begin
                mem_we  = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (load_last || (ptr_q == LAST_PTR)) begin
                    state_d = ST_READY;
                end
            end
        end else if (state_q != ST_EMPTY && state_q != ST_READY) begin
            state_d = ST_EMPTY;
        end
    end

    // Fetch path. A stall freezes all three output registers and drops the
    // request. Without a stall, an idle cycle clears valid and addr_err but
    // leaves the last instruction visible.
    always_comb begin
        fetch_fire    = (state_q == ST_READY) && fetch_req && !fetch_stall;
        addr_in_range = ({1'b0, fetch_addr} < DEPTH_W);
        valid_d       = valid_q;
        instr_d       = instr_q;
        err_d         = err_q;
        if (!fetch_stall) begin
            valid_d = fetch_fire;
            err_d   = 1'b0;
            if (fetch_fire) begin
                if (addr_in_range) begin
                    instr_d = mem_q[fetch_addr];
                end else begin
                    instr_d = NOP_WORD;
                    err_d   = 1'b1;
                end
            end
        end
    end

    // Control and output registers; reset abandons any load in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Program storage has no reset, so words survive reset and any words
    // not rewritten by a later load keep their previous contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= load_data;
        end
    end

    assign ready       = (state_q == ST_READY);
    assign load_count  = count_q;
    assign fetch_valid = valid_q;
    assign fetch_instr = instr_q;
    assign addr_err    = err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// ============================================================================
// tb_instr_mem_loadable
// ----------------------------------------------------------------------------
// Self-checking bench for instr_mem_loadable, built with DEPTH=20 (not a
// power of two) and a non-zero NOP_WORD so out-of-range returns are visible.
// Each stimulus record carries the outputs expected after the next rising
// edge; the expectation is queued when the stimulus is driven and popped
// and compared once the edge has passed.
// ============================================================================
module tb_instr_mem_loadable;

    localparam int              DEPTH = 20;
    localparam int              W     = 9;
    localparam int              AW    = 5;
    localparam logic [W-1:0]    NOP   = 9'h013;

    logic           clk;
    logic           reset;
    logic           load_start;
    logic           load_valid;
    logic [W-1:0]   load_data;
    logic           load_last;
    logic           ready;
    logic [AW:0]    load_count;
    logic           fetch_req;
    logic [AW-1:0]  fetch_addr;
    logic           fetch_stall;
    logic           fetch_valid;
    logic [W-1:0]   fetch_instr;
    logic           addr_err;

    instr_mem_loadable #(
        .DEPTH       (DEPTH),
        .INSTR_WIDTH (W),
        .AW          (AW),
        .NOP_WORD    (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .ready       (ready),
        .load_count  (load_count),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .addr_err    (addr_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic           ls;
        logic           lv;
        logic           ll;
        logic [W-1:0]   ld;
        logic           fr;
        logic [AW-1:0]  fa;
        logic           fs;
        logic           e_ready;
        logic [AW:0]    e_count;
        logic           e_valid;
        logic [W-1:0]   e_instr;
        logic           e_err;
    } vec_t;

    vec_t   vec_table [29];
    vec_t   exp_q [$];
    int     n_checks;
    int     n_passed;

    function automatic vec_t mk(
        input logic ls, input logic lv, input logic ll, input logic [W-1:0] ld,
        input logic fr, input logic [AW-1:0] fa, input logic fs,
        input logic er, input logic [AW:0] ec, input logic ev,
        input logic [W-1:0] ei, input logic ee);
        vec_t v;
        v.ls = ls; v.lv = lv; v.ll = ll; v.ld = ld;
        v.fr = fr; v.fa = fa; v.fs = fs;
        v.e_ready = er; v.e_count = ec; v.e_valid = ev;
        v.e_instr = ei; v.e_err = ee;
        return v;
    endfunction

    task automatic compare(input string name, input logic [15:0] actual,
                           input logic [15:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            compare({tag, ".queue_empty"}, 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            compare({tag, ".ready"},       16'(ready),       16'(e.e_ready));
            compare({tag, ".load_count"},  16'(load_count),  16'(e.e_count));
            compare({tag, ".fetch_valid"}, 16'(fetch_valid), 16'(e.e_valid));
            compare({tag, ".fetch_instr"}, 16'(fetch_instr), 16'(e.e_instr));
            compare({tag, ".addr_err"},    16'(addr_err),    16'(e.e_err));
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, and check just
    // after the rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        load_start  = v.ls;
        load_valid  = v.lv;
        load_last   = v.ll;
        load_data   = v.ld;
        fetch_req   = v.fr;
        fetch_addr  = v.fa;
        fetch_stall = v.fs;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkResetState(input string tag);
        compare({tag, ".ready"},       16'(ready),       16'd0);
        compare({tag, ".load_count"},  16'(load_count),  16'd0);
        compare({tag, ".fetch_valid"}, 16'(fetch_valid), 16'd0);
        compare({tag, ".fetch_instr"}, 16'(fetch_instr), 16'(NOP));
        compare({tag, ".addr_err"},    16'(addr_err),    16'd0);
    endtask

    task automatic idleInputs();
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        load_data   = '0;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;

        // Four-word load with fetch_req held through EMPTY and LOAD, fetches,
        // ignored beats in READY, out-of-range fetch, stalls, and a two-word
        // reload that must leave words 2..3 untouched.
        //                    ls lv ll ld      fr fa  fs  rdy cnt v  instr   err
        vec_table[0]  = mk(0, 0, 0, 9'h000, 1, 0,  0,  0,  0,  0, NOP,    0);
        vec_table[1]  = mk(1, 0, 0, 9'h000, 1, 0,  0,  0,  0,  0, NOP,    0);
        vec_table[2]  = mk(0, 1, 0, 9'h0C0, 1, 0,  0,  0,  1,  0, NOP,    0);
        vec_table[3]  = mk(0, 1, 0, 9'h0E3, 1, 0,  0,  0,  2,  0, NOP,    0);
        vec_table[4]  = mk(0, 1, 0, 9'h145, 1, 0,  0,  0,  3,  0, NOP,    0);
        vec_table[5]  = mk(0, 1, 1, 9'h165, 1, 0,  0,  1,  4,  0, NOP,    0);
        vec_table[6]  = mk(0, 0, 0, 9'h000, 1, 0,  0,  1,  4,  1, 9'h0C0, 0);
        vec_table[7]  = mk(0, 0, 0, 9'h000, 1, 1,  0,  1,  4,  1, 9'h0E3, 0);
        vec_table[8]  = mk(0, 0, 0, 9'h000, 1, 2,  0,  1,  4,  1, 9'h145, 0);
        vec_table[9]  = mk(0, 0, 0, 9'h000, 1, 3,  0,  1,  4,  1, 9'h165, 0);
        vec_table[10] = mk(0, 0, 0, 9'h000, 0, 3,  0,  1,  4,  0, 9'h165, 0);
        vec_table[11] = mk(0, 1, 0, 9'h1AA, 1, 0,  0,  1,  4,  1, 9'h0C0, 0);
        vec_table[12] = mk(0, 0, 0, 9'h000, 1, 25, 0,  1,  4,  1, NOP,    1);
        vec_table[13] = mk(0, 0, 0, 9'h000, 0, 0,  0,  1,  4,  0, NOP,    0);
        vec_table[14] = mk(0, 0, 0, 9'h000, 1, 1,  0,  1,  4,  1, 9'h0E3, 0);
        vec_table[15] = mk(0, 0, 0, 9'h000, 1, 2,  1,  1,  4,  1, 9'h0E3, 0);
        vec_table[16] = mk(0, 0, 0, 9'h000, 0, 2,  1,  1,  4,  1, 9'h0E3, 0);
        vec_table[17] = mk(0, 0, 0, 9'h000, 1, 2,  1,  1,  4,  1, 9'h0E3, 0);
        vec_table[18] = mk(0, 0, 0, 9'h000, 0, 2,  0,  1,  4,  0, 9'h0E3, 0);
        vec_table[19] = mk(0, 0, 0, 9'h000, 1, 30, 0,  1,  4,  1, NOP,    1);
        vec_table[20] = mk(0, 0, 0, 9'h000, 1, 0,  1,  1,  4,  1, NOP,    1);
        vec_table[21] = mk(0, 0, 0, 9'h000, 0, 0,  0,  1,  4,  0, NOP,    0);
        vec_table[22] = mk(1, 0, 0, 9'h000, 0, 0,  0,  0,  0,  0, NOP,    0);
        vec_table[23] = mk(0, 1, 0, 9'h111, 0, 0,  0,  0,  1,  0, NOP,    0);
        vec_table[24] = mk(0, 1, 1, 9'h122, 0, 0,  0,  1,  2,  0, NOP,    0);
        vec_table[25] = mk(0, 0, 0, 9'h000, 1, 0,  0,  1,  2,  1, 9'h111, 0);
        vec_table[26] = mk(0, 0, 0, 9'h000, 1, 1,  0,  1,  2,  1, 9'h122, 0);
        vec_table[27] = mk(0, 0, 0, 9'h000, 1, 2,  0,  1,  2,  1, 9'h145, 0);
        vec_table[28] = mk(0, 0, 0, 9'h000, 1, 3,  0,  1,  2,  1, 9'h165, 0);

        // Reset state before any clock edge, then release between edges.
        idleInputs();
        reset = 1'b1;
        #3;
        checkResetState("reset_init");
        #4;
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            applyStimulus(vec_table[i], $sformatf("table[%0d]", i));
        end

        // Reset in the middle of a load: outputs must clear at once, without
        // waiting for a clock edge.
        applyStimulus(mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h165, 0), "midrst.start");
        applyStimulus(mk(0, 1, 0, 9'h0AA, 0, 0, 0, 0, 1, 0, 9'h165, 0), "midrst.w0");
        applyStimulus(mk(0, 1, 0, 9'h0BB, 0, 0, 0, 0, 2, 0, 9'h165, 0), "midrst.w1");
        idleInputs();
        reset = 1'b1;
        #2;
        checkResetState("midrst.async");
        #2;
        reset = 1'b0;

        // Back in EMPTY: load beats and fetches are ignored, then a full reload.
        applyStimulus(mk(0, 1, 0, 9'h1FF, 1, 0, 0, 0, 0, 0, NOP, 0), "reload.empty");
        applyStimulus(mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, NOP, 0), "reload.start");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(0, 1, (i == 3), W'(9'h1C1 + i), 0, 0, 0,
                             (i == 3), (AW + 1)'(i + 1), 0, NOP, 0),
                          $sformatf("reload.w%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(0, 0, 0, 9'h000, 1, AW'(i), 0,
                             1, 4, 1, W'(9'h1C1 + i), 0),
                          $sformatf("reload.f%0d", i));
        end

        // Full-depth load with no load_last: READY after the 20th beat,
        // later beats ignored.
        applyStimulus(mk(1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h1C4, 0), "full.start");
        for (int i = 0; i < 25; i++) begin
            applyStimulus(mk(0, 1, 0, W'(9'h100 + i), 0, 0, 0,
                             (i >= DEPTH - 1),
                             (AW + 1)'((i + 1 < DEPTH) ? i + 1 : DEPTH),
                             0, 9'h1C4, 0),
                          $sformatf("full.w%0d", i));
        end
        applyStimulus(mk(0, 0, 0, 9'h000, 1, 19, 0, 1, 20, 1, 9'h113, 0), "full.f19");
        applyStimulus(mk(0, 0, 0, 9'h000, 1, 0,  0, 1, 20, 1, 9'h100, 0), "full.f0");
        applyStimulus(mk(0, 0, 0, 9'h000, 1, 20, 0, 1, 20, 1, NOP,    1), "full.f20");
        applyStimulus(mk(0, 0, 0, 9'h000, 1, 25, 0, 1, 20, 1, NOP,    1), "full.f25");
        applyStimulus(mk(0, 0, 0, 9'h000, 0, 0,  0, 1, 20, 0, NOP,    0), "full.idle");

        $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
